// File: rtl/mem_access_if.sv
// Request/response bundle between the MEM pipeline stage and the load/store unit.
interface mem_access_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        misalign_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, misalign_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, misalign_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller in front of a word-only RAM; sub-word stores
// are done as a read-modify-write with a single stall cycle.
module mem_access_unit #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_if.slave       mau,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wea,
  output logic [DATA_W-1:0] ram_wr_data,
  input  logic [DATA_W-1:0] ram_rd_data
);

  typedef enum logic {IDLE, MERGE} state_t;

  state_t state, state_nxt;

  logic              accept;
  logic              legal;
  logic              unused_addr_hi;
  logic [ADDR_W-1:0] waddr_p1;
  logic [1:0]        lane_p1;
  logic              half_p1;
  logic [15:0]       wdata_p1;
  logic [DATA_W-1:0] old_p1;

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   is_aligned = 1'b1;
      2'b01:   is_aligned = ~a[0];
      2'b10:   is_aligned = (a == 2'b00);
      default: is_aligned = 1'b0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word,
                                                    input logic [1:0] size,
                                                    input logic [1:0] a,
                                                    input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic               sb;
    logic               sh;
    b  = word[{a, 3'b000} +: 8];
    h  = word[{a[1], 4'b0000} +: 16];
    sb = b[7] & ~uns;
    sh = h[15] & ~uns;
    case (size)
      2'b00:   load_extend = {{(DATA_W-8){sb}}, b};
      2'b01:   load_extend = {{(DATA_W-16){sh}}, h};
      default: load_extend = word;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] merge_lane(input logic [DATA_W-1:0] old,
                                                   input logic [15:0] wd,
                                                   input logic half,
                                                   input logic [1:0] a);
    logic [DATA_W-1:0] r;
    r = old;
    if (half) r[{a[1], 4'b0000} +: 16] = wd;
    else      r[{a, 3'b000} +: 8]      = wd[7:0];
    merge_lane = r;
  endfunction

  // Upper address bits are intentionally dropped so accesses wrap on RAM size.
  assign unused_addr_hi = ^mau.req_addr[31:ADDR_W+2];

  assign accept = mau.req_valid & (state == IDLE);
  assign legal  = is_aligned(mau.req_size, mau.req_addr[1:0]);

  always_comb begin
    state_nxt     = state;
    mau.req_ready = 1'b0;
    ram_addr      = mau.req_addr[ADDR_W+1:2];
    ram_wea       = 1'b0;
    ram_wr_data   = mau.req_wdata;
    case (state)
      IDLE: begin
        mau.req_ready = 1'b1;
        if (accept && legal && mau.req_we) begin
          if (mau.req_size == 2'b10) ram_wea   = 1'b1;
          else                       state_nxt = MERGE;
        end
      end
      MERGE: begin
        ram_addr    = waddr_p1;
        ram_wea     = 1'b1;
        ram_wr_data = merge_lane(old_p1, wdata_p1, half_p1, lane_p1);
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: control state and load response toward MEM/WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      mau.rsp_valid    <= 1'b0;
      mau.rsp_rdata    <= '0;
      mau.misalign_err <= 1'b0;
    end else begin
      state            <= state_nxt;
      mau.rsp_valid    <= accept & ~mau.req_we;
      mau.misalign_err <= accept & ~legal;
      if (accept && !mau.req_we)
        mau.rsp_rdata <= legal ? load_extend(ram_rd_data, mau.req_size,
                                             mau.req_addr[1:0], mau.req_unsigned)
                               : '0;
    end
  end

  // Stage p1: RMW operands captured on a sub-word store accept
  always_ff @(posedge clk) begin
    if (state == IDLE && state_nxt == MERGE) begin
      waddr_p1 <= mau.req_addr[ADDR_W+1:2];
      lane_p1  <= mau.req_addr[1:0];
      half_p1  <= mau.req_size[0];
      wdata_p1 <= mau.req_wdata[15:0];
      old_p1   <= ram_rd_data;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural async-read/sync-write RAM.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  ram_addr;
  logic        ram_wea;
  logic [31:0] ram_wr_data;
  logic [31:0] ram_rd_data;
  logic [31:0] mem [64];
  int          tests = 0;
  int          fails = 0;

  mem_access_if bus ();

  mem_access_unit #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mau        (bus),
    .ram_addr   (ram_addr),
    .ram_wea    (ram_wea),
    .ram_wr_data(ram_wr_data),
    .ram_rd_data(ram_rd_data)
  );

  always #5 clk = ~clk;

  assign ram_rd_data = mem[ram_addr];
  always @(posedge clk) if (ram_wea) mem[ram_addr] <= ram_wr_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic load(input string tag, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] exp);
    drive(1'b0, size, uns, addr, 32'h0);
    chk({tag, "_wea"}, {31'b0, ram_wea}, 32'd0);
    step();
    chk({tag, "_vld"}, {31'b0, bus.rsp_valid}, 32'd1);
    chk({tag, "_data"}, bus.rsp_rdata, exp);
    chk({tag, "_err"}, {31'b0, bus.misalign_err}, 32'd0);
  endtask

  task automatic store_sub(input string tag, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_word);
    drive(1'b1, size, 1'b0, addr, wdata);
    chk({tag, "_wea0"}, {31'b0, ram_wea}, 32'd0);
    step();
    chk({tag, "_stall"}, {31'b0, bus.req_ready}, 32'd0);
    chk({tag, "_mwea"}, {31'b0, ram_wea}, 32'd1);
    chk({tag, "_maddr"}, {26'b0, ram_addr}, {26'b0, addr[7:2]});
    chk({tag, "_mdata"}, ram_wr_data, exp_word);
    @(posedge clk);
    #1;
    chk({tag, "_word"}, mem[addr[7:2]], exp_word);
    chk({tag, "_ready"}, {31'b0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rst_vld", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_err", {31'b0, bus.misalign_err}, 32'd0);
    chk("rst_wea", {31'b0, ram_wea}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // T1: full-word store then load
    drive(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    chk("t1_addr", {26'b0, ram_addr}, 32'd4);
    chk("t1_wea", {31'b0, ram_wea}, 32'd1);
    chk("t1_wdata", ram_wr_data, 32'hDEADBEEF);
    chk("t1_ready", {31'b0, bus.req_ready}, 32'd1);
    step();
    chk("t1_word", mem[4], 32'hDEADBEEF);
    chk("t1_novld", {31'b0, bus.rsp_valid}, 32'd0);
    load("t1_lw", 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    @(posedge clk);
    #1;
    chk("t1_pulse", {31'b0, bus.rsp_valid}, 32'd0);
    chk("t1_hold", bus.rsp_rdata, 32'hDEADBEEF);

    // T2: byte store RMW
    store_sub("t2_sb", 2'b00, 32'h11, 32'h000000AA, 32'hDEADAAEF);
    load("t2_lw", 2'b10, 1'b0, 32'h10, 32'hDEADAAEF);

    // T3: sub-word loads and half store
    load("t3_lb", 2'b00, 1'b0, 32'h13, 32'hFFFFFFDE);
    load("t3_lbu", 2'b00, 1'b1, 32'h13, 32'h000000DE);
    load("t3_lh", 2'b01, 1'b0, 32'h12, 32'hFFFFDEAD);
    load("t3_lhu", 2'b01, 1'b1, 32'h12, 32'h0000DEAD);
    load("t3_lb0", 2'b00, 1'b0, 32'h10, 32'hFFFFFFEF);
    store_sub("t3_sh", 2'b01, 32'h12, 32'h00001234, 32'h1234AAEF);

    // T4: misaligned and illegal-size accesses
    drive(1'b0, 2'b01, 1'b0, 32'h11, 32'h0);
    chk("t4_lh_wea", {31'b0, ram_wea}, 32'd0);
    step();
    chk("t4_lh_err", {31'b0, bus.misalign_err}, 32'd1);
    chk("t4_lh_vld", {31'b0, bus.rsp_valid}, 32'd1);
    chk("t4_lh_data", bus.rsp_rdata, 32'd0);
    drive(1'b1, 2'b10, 1'b0, 32'h12, 32'hFFFFFFFF);
    chk("t4_sw_wea", {31'b0, ram_wea}, 32'd0);
    step();
    chk("t4_sw_err", {31'b0, bus.misalign_err}, 32'd1);
    chk("t4_sw_vld", {31'b0, bus.rsp_valid}, 32'd0);
    chk("t4_sw_ready", {31'b0, bus.req_ready}, 32'd1);
    drive(1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFFFFFF);
    chk("t4_s11_wea", {31'b0, ram_wea}, 32'd0);
    step();
    chk("t4_s11_err", {31'b0, bus.misalign_err}, 32'd1);
    chk("t4_word", mem[4], 32'h1234AAEF);
    @(posedge clk);
    #1;
    chk("t4_err_pulse", {31'b0, bus.misalign_err}, 32'd0);

    // T5: reset during MERGE aborts the RMW
    drive(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344);
    step();
    chk("t5_pre", mem[8], 32'h11223344);
    drive(1'b1, 2'b00, 1'b0, 32'h20, 32'h00000055);
    step();
    chk("t5_in_merge", {31'b0, bus.req_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_wea", {31'b0, ram_wea}, 32'd0);
    chk("t5_rst_ready", {31'b0, bus.req_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("t5_word", mem[8], 32'h11223344);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t5_ready", {31'b0, bus.req_ready}, 32'd1);
    load("t5_lw", 2'b10, 1'b0, 32'h20, 32'h11223344);

    // T6: load held behind an RMW stall, then address wrap
    drive(1'b1, 2'b00, 1'b0, 32'h21, 32'h00000077);
    @(posedge clk);
    #1;
    bus.req_we   = 1'b0;
    bus.req_size = 2'b10;
    bus.req_addr = 32'h20;
    #1;
    chk("t6_stall", {31'b0, bus.req_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("t6_no_early", {31'b0, bus.rsp_valid}, 32'd0);
    chk("t6_merged", mem[8], 32'h11227744);
    chk("t6_ready", {31'b0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("t6_lw_vld", {31'b0, bus.rsp_valid}, 32'd1);
    chk("t6_lw_data", bus.rsp_rdata, 32'h11227744);
    drive(1'b1, 2'b10, 1'b0, 32'h104, 32'hCAFEF00D);
    chk("t6_wrap_addr", {26'b0, ram_addr}, 32'd1);
    chk("t6_wrap_wea", {31'b0, ram_wea}, 32'd1);
    step();
    chk("t6_wrap_word", mem[1], 32'hCAFEF00D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
